// File: rtl/mcu_pkg.sv
// mcu_pkg: shared types for the parametrised accumulator core.
//   state_t  - core sequencer states (also exported on the state port)
//   opcode_t - 4-bit instruction opcodes held in IR[INSTR_W-1 -: 4]
//   FLAG_*   - bit positions inside the {Z,C} flag register
package mcu_pkg;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_ADDI = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_JC   = 4'hA,
    OP_HLT  = 4'hF
  } opcode_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;

endpackage

// File: rtl/mcu_alu.sv
// mcu_alu: combinational accumulator ALU.
//   a         - current accumulator
//   b         - operand (immediate K or data register, chosen by the core)
//   op        - opcode being executed
//   flags_in  - {Z,C} before this instruction
//   result    - new accumulator value (a unchanged for non-ALU opcodes)
//   flags_out - {Z,C} after this instruction
module mcu_alu
  import mcu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_t           op,
  input  logic [1:0]        flags_in,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        flags_out
);

  logic [DATA_W:0] wide;
  logic            upd_z;

  always_comb begin
    wide      = '0;
    result    = a;
    flags_out = flags_in;
    upd_z     = 1'b0;
    case (op)
      OP_LDI, OP_LD: begin
        result = b;
        upd_z  = 1'b1;
      end
      OP_ADD, OP_ADDI: begin
        wide              = {1'b0, a} + {1'b0, b};
        result            = wide[DATA_W-1:0];
        flags_out[FLAG_C] = wide[DATA_W];
        upd_z             = 1'b1;
      end
      OP_SUB: begin
        // top bit of the widened difference is the borrow
        wide              = {1'b0, a} - {1'b0, b};
        result            = wide[DATA_W-1:0];
        flags_out[FLAG_C] = wide[DATA_W];
        upd_z             = 1'b1;
      end
      OP_AND: begin
        result = a & b;
        upd_z  = 1'b1;
      end
      default: ;
    endcase
    if (upd_z) flags_out[FLAG_Z] = (result == '0);
  end

endmodule

// File: rtl/mcu_core_param.sv
// mcu_core_param: multi-cycle accumulator microcontroller with streamed
// program load.
//   clk, rst            - clock, async active-low reset
//   ld_valid/ready/data/last - program load stream (accepted in LOAD only)
//   run_en              - 0 stalls the core in FETCH
//   reload              - pulse in HALT returns to LOAD
//   pc, acc, flags      - architectural state ({Z,C})
//   halted, state       - status
module mcu_core_param
  import mcu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16,
  localparam int INSTR_W   = DATA_W + 4,
  localparam int PA_W      = $clog2(PMEM_DEPTH),
  localparam int DA_W      = $clog2(DMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               ld_last,
  input  logic               run_en,
  input  logic               reload,
  output logic [PA_W-1:0]    pc,
  output logic [DATA_W-1:0]  acc,
  output logic [1:0]         flags,
  output logic               halted,
  output logic [2:0]         state
);

  state_t              cur_st, nxt_st;
  logic [PA_W-1:0]     pc_q, load_addr;
  logic [DATA_W-1:0]   acc_q, dr_q;
  logic [1:0]          flags_q;
  logic [INSTR_W-1:0]  ir_q;

  logic [INSTR_W-1:0]  pmem [PMEM_DEPTH];
  logic [DATA_W-1:0]   dmem [DMEM_DEPTH];

  opcode_t             op;
  logic [DATA_W-1:0]   k, alu_b, alu_res;
  logic [1:0]          alu_flags;
  logic                ld_fire, ld_done, br_take;

  assign op = opcode_t'(ir_q[INSTR_W-1 -: 4]);
  assign k  = ir_q[DATA_W-1:0];

  assign ld_ready = (cur_st == ST_LOAD);
  assign ld_fire  = ld_ready && ld_valid;
  // a full memory completes the load even without ld_last
  assign ld_done  = ld_fire && (ld_last || load_addr == PA_W'(PMEM_DEPTH - 1));

  // jump conditions look at flags before this EXECUTE commits
  assign br_take = (op == OP_JMP) ||
                   (op == OP_JZ && flags_q[FLAG_Z]) ||
                   (op == OP_JC && flags_q[FLAG_C]);

  assign alu_b = (op == OP_LDI || op == OP_ADDI) ? k : dr_q;

  mcu_alu #(.DATA_W(DATA_W)) u_alu (
    .a         (acc_q),
    .b         (alu_b),
    .op        (op),
    .flags_in  (flags_q),
    .result    (alu_res),
    .flags_out (alu_flags)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur_st <= ST_LOAD;
    else      cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      ST_LOAD:    if (ld_done) nxt_st = ST_FETCH;
      ST_FETCH:   if (run_en)  nxt_st = ST_DECODE;
      ST_DECODE:  nxt_st = ST_EXECUTE;
      ST_EXECUTE: nxt_st = (op == OP_HLT) ? ST_HALT : ST_FETCH;
      ST_HALT:    if (reload)  nxt_st = ST_LOAD;
      default:    nxt_st = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= '0;
      acc_q     <= '0;
      flags_q   <= '0;
      ir_q      <= '0;
      dr_q      <= '0;
      load_addr <= '0;
    end else begin
      case (cur_st)
        ST_LOAD: begin
          if (ld_fire) load_addr <= ld_done ? '0 : load_addr + PA_W'(1);
          if (ld_done) begin
            pc_q    <= '0;
            acc_q   <= '0;
            flags_q <= '0;
            ir_q    <= '0;
            dr_q    <= '0;
          end
        end
        ST_FETCH:  if (run_en) ir_q <= pmem[pc_q];
        ST_DECODE: dr_q <= dmem[ir_q[DA_W-1:0]];
        ST_EXECUTE: begin
          acc_q   <= alu_res;
          flags_q <= alu_flags;
          // HLT leaves pc pointing at itself
          if (op != OP_HLT) pc_q <= br_take ? k[PA_W-1:0] : pc_q + PA_W'(1);
        end
        ST_HALT:   if (reload) load_addr <= '0;
        default: ;
      endcase
    end
  end

  // memories carry no reset so they map onto plain RAM
  always_ff @(posedge clk) begin
    if (ld_fire) pmem[load_addr] <= ld_data;
    if (cur_st == ST_EXECUTE && op == OP_ST) dmem[k[DA_W-1:0]] <= acc_q;
  end

  assign pc     = pc_q;
  assign acc    = acc_q;
  assign flags  = flags_q;
  assign halted = (cur_st == ST_HALT);
  assign state  = cur_st;

endmodule

// File: tb/tb_mcu_core_param.sv
// tb_mcu_core_param: directed bench for mcu_core_param. Hand sequences cover
// load timing, stall, auto-complete load and mid-load reset; a table of
// small programs with hand-computed final acc/flags/pc covers the ISA.
module tb_mcu_core_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid, ld_ready, ld_last, run_en, reload, halted;
  logic [11:0] ld_data;
  logic [3:0]  pc;
  logic [7:0]  acc;
  logic [1:0]  flags;
  logic [2:0]  st;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mcu_core_param dut (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .run_en   (run_en),
    .reload   (reload),
    .pc       (pc),
    .acc      (acc),
    .flags    (flags),
    .halted   (halted),
    .state    (st)
  );

  typedef struct {
    logic [11:0] w [8];
    int          len;
    logic [7:0]  e_acc;
    logic [1:0]  e_flags;
    logic [3:0]  e_pc;
  } vec_t;

  vec_t        vecs [9];
  logic [11:0] buf_w [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [11:0] w0, w1, w2, w3, w4, w5, w6, w7,
                         input int len, input logic [7:0] ea, input logic [1:0] ef,
                         input logic [3:0] ep);
    vecs[i].w[0] = w0; vecs[i].w[1] = w1; vecs[i].w[2] = w2; vecs[i].w[3] = w3;
    vecs[i].w[4] = w4; vecs[i].w[5] = w5; vecs[i].w[6] = w6; vecs[i].w[7] = w7;
    vecs[i].len = len; vecs[i].e_acc = ea; vecs[i].e_flags = ef; vecs[i].e_pc = ep;
  endtask

  // streams buf_w[start +: n]; optional idle cycle between words
  task automatic load_words(input int start, input int n, input bit gaps, input bit use_last);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = buf_w[start + i];
      ld_last  = use_last && (i == n - 1);
      @(posedge clk); #1;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      if (gaps && i < n - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_reload(input string nm);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    chk({nm, " reload state"}, 32'(st), 32'd0);
    chk({nm, " reload ld_ready"}, 32'(ld_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    rst = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    run_en = 1'b1; reload = 1'b0;

    // program table: {words}, len, acc, {Z,C}, pc at HALT
    set_vec(0, 12'h1FF, 12'h701, 12'hA05, 12'h000, 12'h000, 12'hF00, 0, 0, 6, 8'h00, 2'b11, 4'd5);
    set_vec(1, 12'h101, 12'h904, 12'hF00, 12'h000, 12'hF00, 0, 0, 0,        5, 8'h01, 2'b00, 4'd2);
    set_vec(2, 12'h1A5, 12'h303, 12'h100, 12'h203, 12'h503, 12'hF00, 0, 0, 6, 8'h00, 2'b10, 4'd5);
    set_vec(3, 12'h203, 12'hF00, 0, 0, 0, 0, 0, 0,                          2, 8'hA5, 2'b00, 4'd1);
    set_vec(4, 12'h1F0, 12'h301, 12'h1FF, 12'h701, 12'h13C, 12'h601, 12'hF00, 0, 7, 8'h30, 2'b01, 4'd6);
    set_vec(5, 12'h180, 12'h302, 12'h190, 12'h402, 12'hF00, 0, 0, 0,        5, 8'h10, 2'b01, 4'd4);
    set_vec(6, 12'h101, 12'h304, 12'h100, 12'h504, 12'hF00, 0, 0, 0,        5, 8'hFF, 2'b01, 4'd4);
    set_vec(7, 12'h803, 12'h107, 12'hF00, 12'h109, 12'hF00, 0, 0, 0,        5, 8'h09, 2'b00, 4'd4);
    set_vec(8, 12'h100, 12'h904, 12'h105, 12'hF00, 12'hF00, 0, 0, 0,        5, 8'h00, 2'b10, 4'd4);

    // reset values while held
    #12;
    chk("rst state", 32'(st), 32'd0);
    chk("rst pc", 32'(pc), 32'd0);
    chk("rst acc", 32'(acc), 32'd0);
    chk("rst flags", 32'(flags), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst ld_ready", 32'(ld_ready), 32'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // gapped load of LDI 5; ADDI 3; HLT
    buf_w[0] = 12'h105; buf_w[1] = 12'h703; buf_w[2] = 12'hF00;
    load_words(0, 3, 1'b1, 1'b1);
    chk("load->fetch state", 32'(st), 32'd1);
    chk("load->fetch pc", 32'(pc), 32'd0);
    chk("load->fetch ld_ready", 32'(ld_ready), 32'd0);
    run_to_halt(cyc);
    chk("prog1 cycles", 32'(cyc), 32'd9);
    chk("prog1 acc", 32'(acc), 32'h08);
    chk("prog1 flags", 32'(flags), 32'd0);
    chk("prog1 pc", 32'(pc), 32'd2);
    chk("prog1 halted", 32'(halted), 32'd1);
    do_reload("prog1");

    // run_en stall after the first instruction
    load_words(0, 3, 1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    chk("pre-stall pc", 32'(pc), 32'd1);
    chk("pre-stall acc", 32'(acc), 32'h05);
    run_en = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("stall state", 32'(st), 32'd1);
    chk("stall pc", 32'(pc), 32'd1);
    chk("stall acc", 32'(acc), 32'h05);
    run_en = 1'b1;
    run_to_halt(cyc);
    chk("post-stall cycles", 32'(cyc), 32'd6);
    chk("post-stall acc", 32'(acc), 32'h08);
    do_reload("stall");

    // full-depth load without ld_last
    buf_w[0] = 12'h107;
    for (int i = 1; i < 15; i++) buf_w[i] = 12'h000;
    buf_w[15] = 12'hF00;
    load_words(0, 15, 1'b0, 1'b0);
    chk("autoload 15 state", 32'(st), 32'd0);
    load_words(15, 1, 1'b0, 1'b0);
    chk("autoload 16 state", 32'(st), 32'd1);
    run_to_halt(cyc);
    chk("autoload acc", 32'(acc), 32'h07);
    chk("autoload pc", 32'(pc), 32'd15);
    do_reload("autoload");

    // reset after 2 of 4 words; those words would halt with acc 9 if kept at 0..1 after restart
    buf_w[0] = 12'h109; buf_w[1] = 12'hF00;
    load_words(0, 2, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst state", 32'(st), 32'd0);
    chk("midrst pc", 32'(pc), 32'd0);
    chk("midrst acc", 32'(acc), 32'd0);
    chk("midrst flags", 32'(flags), 32'd0);
    chk("midrst halted", 32'(halted), 32'd0);
    chk("midrst ld_ready", 32'(ld_ready), 32'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    buf_w[0] = 12'h102; buf_w[1] = 12'h702; buf_w[2] = 12'h000; buf_w[3] = 12'hF00;
    load_words(0, 4, 1'b0, 1'b1);
    run_to_halt(cyc);
    chk("reload0 acc", 32'(acc), 32'h04);
    chk("reload0 pc", 32'(pc), 32'd3);
    do_reload("reload0");

    // ISA table
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < vecs[v].len; i++) buf_w[i] = vecs[v].w[i];
      load_words(0, vecs[v].len, 1'b0, 1'b1);
      run_to_halt(cyc);
      chk($sformatf("vec%0d halted", v), 32'(halted), 32'd1);
      chk($sformatf("vec%0d acc", v), 32'(acc), 32'(vecs[v].e_acc));
      chk($sformatf("vec%0d flags", v), 32'(flags), 32'(vecs[v].e_flags));
      chk($sformatf("vec%0d pc", v), 32'(pc), 32'(vecs[v].e_pc));
      do_reload($sformatf("vec%0d", v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
